// File: rtl/lfsr_pkg.sv
// Shared types and primitive-polynomial tap masks for lfsr_gen.
// Mask bit k set means reg[k] feeds the Fibonacci XOR; entries 0 and 1 are unused.
package lfsr_pkg;

   typedef enum logic {FIB, GAL} lfsr_mode_e;
   typedef enum logic {IDLE, RUN} lfsr_state_e;

   localparam logic [15:0] LFSR_TAPS [17] = '{
      16'h0000, 16'h0000, 16'h0003, 16'h0006, 16'h000C, 16'h0014,
      16'h0030, 16'h0060, 16'h00B8, 16'h0110, 16'h0240, 16'h0500,
      16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
   };

endpackage

// File: rtl/lfsr_gen_next.sv
// Combinational next-value logic for lfsr_gen, Fibonacci or Galois form.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int unsigned      N    = 8,
   parameter logic [N-1:0]     TAPS = LFSR_TAPS[N][N-1:0]
) (
   input  logic [N-1:0] cur,
   input  lfsr_mode_e   mode,
   output logic [N-1:0] nxt
);

   always_comb begin
      nxt = '0;
      if (mode == GAL) begin
         // Galois form reuses the Fibonacci mask, shifted so the x^0 term is always fed.
         nxt = {cur[N-2:0], 1'b0} ^ ({N{cur[N-1]}} & {TAPS[N-2:0], 1'b1});
      end else begin
         nxt = {cur[N-2:0], ^(cur & TAPS)};
      end
   end

endmodule

// File: rtl/lfsr_gen.sv
// Maximal-length LFSR generator with seed load, step enable and per-period done pulse.
// Optional short-period detector enabled by defining LFSR_PERIOD_CHK_EN.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned  N    = 8,
   parameter logic [N-1:0] TAPS = LFSR_TAPS[N][N-1:0]
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_seed,
   input  logic [N-1:0] seed_data,
   input  logic         mode,
   input  logic         step_en,
   output logic [N-1:0] lfsr_data,
   output logic         lfsr_valid,
   output logic         lfsr_done,
   output logic         seed_err,
   output logic         period_err
);

   localparam logic [N-1:0] LastCount = {{(N-1){1'b1}}, 1'b0};

   lfsr_state_e  state_q, state_d;
   lfsr_mode_e   mode_q, mode_d;
   logic [N-1:0] lfsr_q, lfsr_d;
   logic [N-1:0] count_q, count_d;
   logic         done_q, done_d;
   logic         seed_err_q, seed_err_d;
   logic [N-1:0] lfsr_nxt;
   logic [N-1:0] seed_eff;
   logic         step;

   lfsr_next #(
      .N    (N),
      .TAPS (TAPS)
   ) u_next (
      .cur  (lfsr_q),
      .mode (mode_q),
      .nxt  (lfsr_nxt)
   );

   assign seed_eff = (seed_data == '0) ? {{(N-1){1'b0}}, 1'b1} : seed_data;
   // Load has priority over step.
   assign step     = !load_seed && (state_q == RUN) && step_en;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      lfsr_d     = lfsr_q;
      count_d    = count_q;
      done_d     = 1'b0;
      seed_err_d = 1'b0;
      if (load_seed) begin
         state_d    = RUN;
         mode_d     = lfsr_mode_e'(mode);
         lfsr_d     = seed_eff;
         count_d    = '0;
         seed_err_d = (seed_data == '0);
      end else if (step) begin
         lfsr_d = lfsr_nxt;
         if (count_q == LastCount) begin
            count_d = '0;
            done_d  = 1'b1;
         end else begin
            count_d = count_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         mode_q     <= FIB;
         lfsr_q     <= '0;
         count_q    <= '0;
         done_q     <= 1'b0;
         seed_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         lfsr_q     <= lfsr_d;
         count_q    <= count_d;
         done_q     <= done_d;
         seed_err_q <= seed_err_d;
      end
   end

`ifdef LFSR_PERIOD_CHK_EN
   logic [N-1:0] seed_q, seed_d;
   logic         period_err_q, period_err_d;

   always_comb begin
      seed_d       = seed_q;
      period_err_d = period_err_q;
      if (load_seed) begin
         seed_d       = seed_eff;
         period_err_d = 1'b0;
      end else if (step && (lfsr_nxt == seed_q) && (count_q != LastCount)) begin
         period_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         seed_q       <= '0;
         period_err_q <= 1'b0;
      end else begin
         seed_q       <= seed_d;
         period_err_q <= period_err_d;
      end
   end

   assign period_err = period_err_q;
`else
   assign period_err = 1'b0;
`endif

   assign lfsr_data  = lfsr_q;
   assign lfsr_valid = (state_q == RUN);
   assign lfsr_done  = done_q;
   assign seed_err   = seed_err_q;

endmodule
